// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back stage with 15x64b register file and status FSM.
// Optional WB_BYPASS_EN forwards same-cycle writes onto the read ports.
module writeback_regfile #(
  parameter int DATA_W  = 64,
  parameter int NREGS   = 15,
  parameter int RSP_IDX = 4,
  parameter int CNT_W   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        in_code,
  input  logic [3:0]        in_fun,
  input  logic              cnd,
  input  logic [3:0]        ra,
  input  logic [3:0]        rb,
  input  logic [DATA_W-1:0] val_e,
  input  logic [DATA_W-1:0] val_m,
  input  logic [3:0]        rd_src_a,
  input  logic [3:0]        rd_src_b,
  output logic [DATA_W-1:0] rd_val_a,
  output logic [DATA_W-1:0] rd_val_b,
  output logic [2:0]        stat,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'(RSP_IDX);

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t state, state_d;

  logic [DATA_W-1:0] regs [NREGS];

  logic [3:0] dst_e;
  logic [3:0] dst_m;
  logic       is_halt;
  logic       is_bad;
  logic       accept;
  logic       wr;
  logic       we_e;
  logic       we_m;

  logic unused_fun;
  assign unused_fun = ^in_fun;

  always_comb begin
    dst_e   = RNONE;
    dst_m   = RNONE;
    is_halt = 1'b0;
    is_bad  = 1'b0;
    case (in_code)
      I_HALT:  is_halt = 1'b1;
      I_NOP:   ;
      I_RRMOV: dst_e = cnd ? rb : RNONE;
      I_IRMOV: dst_e = rb;
      I_RMMOV: ;
      I_MRMOV: dst_m = ra;
      I_OPQ:   dst_e = rb;
      I_JXX:   ;
      I_CALL:  dst_e = RSP;
      I_RET:   dst_e = RSP;
      I_PUSH:  dst_e = RSP;
      I_POP: begin
        dst_e = RSP;
        dst_m = ra;
      end
      default: is_bad = 1'b1;
    endcase
  end

  assign wb_ready = (state == RUN);
  assign accept   = wb_valid & wb_ready;
  // Reset wins over an accept landing on the same edge.
  assign wr       = accept & reset_n & ~is_bad;
  assign we_m     = wr & (dst_m != RNONE);
  assign we_e     = wr & (dst_e != RNONE) & (dst_e != dst_m);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= RUN;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    stat    = 3'd1;
    case (state)
      RUN: begin
        stat = 3'd1;
        if (wb_valid) begin
          if (is_halt)     state_d = HALT;
          else if (is_bad) state_d = ERR;
        end
      end
      HALT:    stat = 3'd2;
      ERR:     stat = 3'd4;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we_m) regs[dst_m] <= val_m;
      if (we_e) regs[dst_e] <= val_e;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      retired <= '0;
    else if (accept && !is_bad)
      retired <= retired + CNT_W'(1);
  end

  always_comb begin
    rd_val_a = '0;
    if (rd_src_a < 4'(NREGS)) rd_val_a = regs[rd_src_a];
`ifdef WB_BYPASS_EN
    if (we_e && dst_e == rd_src_a) rd_val_a = val_e;
    if (we_m && dst_m == rd_src_a) rd_val_a = val_m;
`endif
  end

  always_comb begin
    rd_val_b = '0;
    if (rd_src_b < 4'(NREGS)) rd_val_b = regs[rd_src_b];
`ifdef WB_BYPASS_EN
    if (we_e && dst_e == rd_src_b) rd_val_b = val_e;
    if (we_m && dst_m == rd_src_b) rd_val_b = val_m;
`endif
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with an instruction-level model.
// Honors WB_BYPASS_EN when the same define is given to the bench.
module tb_writeback_regfile;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  in_code;
  logic [3:0]  in_fun;
  logic        cnd;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [63:0] val_e;
  logic [63:0] val_m;
  logic [3:0]  rd_src_a;
  logic [3:0]  rd_src_b;
  logic [63:0] rd_val_a;
  logic [63:0] rd_val_b;
  logic [2:0]  stat;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  logic [63:0] m_regs [15];
  int          m_stat;
  logic [31:0] m_ret;

  writeback_regfile dut (
    .clock(clock), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .in_code(in_code), .in_fun(in_fun), .cnd(cnd),
    .ra(ra), .rb(rb), .val_e(val_e), .val_m(val_m),
    .rd_src_a(rd_src_a), .rd_src_b(rd_src_b),
    .rd_val_a(rd_val_a), .rd_val_b(rd_val_b),
    .stat(stat), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Destinations straight from the icode table; 15 means none.
  function automatic int dst_e_of(input int code, input bit c, input int b);
    if (code == 2) return c ? b : 15;
    if (code == 3 || code == 6) return b;
    if (code >= 8 && code <= 11) return 4;
    return 15;
  endfunction

  function automatic int dst_m_of(input int code, input int a);
    if (code == 5 || code == 11) return a;
    return 15;
  endfunction

  function automatic logic [63:0] exp_rd(input int idx);
    if (idx == 15) return 64'd0;
`ifdef WB_BYPASS_EN
    if (reset_n && wb_valid && m_stat == 1 && in_code <= 11) begin
      int de, dm;
      de = dst_e_of(in_code, cnd, rb);
      dm = dst_m_of(in_code, ra);
      if (dm != 15 && dm == idx) return val_m;
      if (de != 15 && de == idx) return val_e;
    end
`endif
    return m_regs[idx];
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
      m_stat = 1;
      m_ret  = 32'd0;
    end else if (wb_valid && m_stat == 1) begin
      if (in_code > 11) begin
        m_stat = 4;
      end else begin
        int de, dm;
        de = dst_e_of(in_code, cnd, rb);
        dm = dst_m_of(in_code, ra);
        if (de != 15 && de != dm) m_regs[de] = val_e;
        if (dm != 15) m_regs[dm] = val_m;
        m_ret = m_ret + 32'd1;
        if (in_code == 0) m_stat = 2;
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("stat", 64'(stat), 64'(m_stat));
      check("wb_ready", 64'(wb_ready), 64'(m_stat == 1));
      check("retired", 64'(retired), 64'(m_ret));
      check("rd_val_a", rd_val_a, exp_rd(int'(rd_src_a)));
      check("rd_val_b", rd_val_b, exp_rd(int'(rd_src_b)));
    end
  end

  task automatic step(input bit v, input int code, input bit c,
                      input int a, input int b,
                      input logic [63:0] ve, input logic [63:0] vm,
                      input int sa, input int sb);
    @(posedge clock);
    #1;
    wb_valid = v;
    in_code  = 4'(code);
    in_fun   = 4'h0;
    cnd      = c;
    ra       = 4'(a);
    rb       = 4'(b);
    val_e    = ve;
    val_m    = vm;
    rd_src_a = 4'(sa);
    rd_src_b = 4'(sb);
  endtask

  task automatic idle(input int sa, input int sb);
    step(0, 1, 0, 15, 15, 64'd0, 64'd0, sa, sb);
  endtask

  task automatic ins(input int code, input bit c, input int a, input int b,
                     input logic [63:0] ve, input logic [63:0] vm);
    step(1, code, c, a, b, ve, vm, 15, 15);
  endtask

  initial begin
    reset_n = 1'b0;
    wb_valid = 0; in_code = 0; in_fun = 0; cnd = 0;
    ra = 15; rb = 15; val_e = 0; val_m = 0;
    rd_src_a = 15; rd_src_b = 15;
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    started = 1;

    for (int i = 0; i < 16; i++) idle(i, 15 - i);
    @(negedge clock);
    check("lit_reset_stat", 64'(stat), 64'd1);
    check("lit_reset_ret", 64'(retired), 64'd0);

    ins(3, 0, 15, 3, 64'h1234, 64'd0);
    idle(3, 15);
    @(negedge clock);
    check("lit_irmov", rd_val_a, 64'h1234);
    check("lit_irmov_ret", 64'(retired), 64'd1);

    ins(2, 0, 1, 2, 64'd5, 64'd0);
    idle(2, 3);
    @(negedge clock);
    check("lit_cmov_nc", rd_val_a, 64'd0);
    ins(2, 1, 1, 2, 64'd5, 64'd0);
    idle(2, 3);
    @(negedge clock);
    check("lit_cmov_c", rd_val_a, 64'd5);

    ins(11, 0, 4, 15, 64'h100, 64'hBEEF);
    idle(4, 15);
    @(negedge clock);
    check("lit_pop_rsp", rd_val_a, 64'hBEEF);
    ins(11, 0, 1, 15, 64'h100, 64'hBEEF);
    idle(4, 1);
    @(negedge clock);
    check("lit_pop_r4", rd_val_a, 64'h100);
    check("lit_pop_r1", rd_val_b, 64'hBEEF);

    ins(5, 0, 7, 15, 64'hDEAD, 64'h77);
    step(1, 6, 0, 15, 6, 64'd9, 64'd0, 6, 7);
    @(negedge clock);
`ifdef WB_BYPASS_EN
    check("lit_bypass", rd_val_a, 64'd9);
`else
    check("lit_nobypass", rd_val_a, 64'd0);
`endif
    check("lit_mrmov", rd_val_b, 64'h77);
    ins(8, 0, 15, 15, 64'h200, 64'd0);
    ins(9, 0, 15, 15, 64'h208, 64'h40);
    ins(10, 0, 15, 15, 64'h1F8, 64'd0);
    ins(1, 0, 5, 5, 64'h55, 64'h55);
    ins(4, 0, 5, 5, 64'h66, 64'h66);
    ins(7, 1, 5, 5, 64'h77, 64'h77);
    idle(4, 5);
    @(negedge clock);
    check("lit_push_rsp", rd_val_a, 64'h1F8);
    check("lit_nop_r5", rd_val_b, 64'd0);

    ins(0, 0, 15, 15, 64'd0, 64'd0);
    idle(15, 15);
    @(negedge clock);
    check("lit_halt_stat", 64'(stat), 64'd2);
    check("lit_halt_ready", 64'(wb_ready), 64'd0);
    check("lit_halt_ret", 64'(retired), 64'd14);
    ins(3, 0, 15, 8, 64'hAA, 64'd0);
    idle(8, 15);
    @(negedge clock);
    check("lit_halt_nowr", rd_val_a, 64'd0);
    check("lit_halt_ret2", 64'(retired), 64'd14);

    ins(3, 0, 15, 3, 64'hFF, 64'd0);
    reset_n = 1'b0;
    idle(3, 15);
    reset_n = 1'b1;
    @(negedge clock);
    check("lit_rst_stat", 64'(stat), 64'd1);
    check("lit_rst_r3", rd_val_a, 64'd0);
    check("lit_rst_ret", 64'(retired), 64'd0);

    step(1, 13, 0, 9, 9, 64'h99, 64'h99, 9, 15);
    idle(9, 15);
    @(negedge clock);
    check("lit_bad_stat", 64'(stat), 64'd4);
    check("lit_bad_nowr", rd_val_a, 64'd0);
    check("lit_bad_ret", 64'(retired), 64'd0);
    ins(3, 0, 15, 9, 64'h12, 64'd0);
    idle(9, 15);
    @(negedge clock);
    check("lit_err_nowr", rd_val_a, 64'd0);
    check("lit_err_ready", 64'(wb_ready), 64'd0);

    idle(15, 15);
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
